// File: rtl/operand_issuer.sv
// operand_issuer: FIFO-buffered command feeder presenting A, B and OP to the
// arithmetic controller as ordered stable/ack transfers with return-to-idle.
`timescale 1ns/1ps
module operand_issuer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_a,
  input  logic [31:0]             cmd_b,
  input  logic [2:0]              cmd_op,
  output logic [31:0]             output_a,
  output logic [31:0]             output_b,
  output logic [2:0]              output_op,
  output logic                    output_a_stable,
  output logic                    output_b_stable,
  output logic                    output_op_stable,
  input  logic                    input_a_ack,
  input  logic                    input_b_ack,
  input  logic                    input_op_ack,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              issued
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_A   = 3'd1;
  localparam logic [2:0] SEND_B   = 3'd2;
  localparam logic [2:0] SEND_OP  = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic [7:0]    issued_q;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;
  logic          a_stb_q, b_stb_q, op_stb_q;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [2:0]    mem_op [DEPTH];
  logic          push, pop, load;
  // Full is judged on registered occupancy only, so a same-edge pop never frees a slot.
  assign cmd_ready = count_q != FULL;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state_q == SEND_OP && input_op_ack;
  assign load      = state_q == IDLE && count_q != '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = count_q != '0 ? SEND_A : IDLE;
      SEND_A:   state_d = input_a_ack ? SEND_B : SEND_A;
      SEND_B:   state_d = input_b_ack ? SEND_OP : SEND_B;
      SEND_OP:  state_d = input_op_ack ? WAIT_REL : SEND_OP;
      WAIT_REL: state_d = (input_a_ack || input_b_ack || input_op_ack) ? WAIT_REL : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      issued_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      op_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_stb_q  <= state_d == SEND_A;
      b_stb_q  <= state_d == SEND_B;
      op_stb_q <= state_d == SEND_OP;
      count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q     <= rd_q + AW'(1);
        issued_q <= issued_q + 8'd1;
      end
      if (load) begin
        a_q  <= mem_a[rd_q];
        b_q  <= mem_b[rd_q];
        op_q <= mem_op[rd_q];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_q]  <= cmd_a;
      mem_b[wr_q]  <= cmd_b;
      mem_op[wr_q] <= cmd_op;
    end
  end
  assign output_a         = a_q;
  assign output_b         = b_q;
  assign output_op        = op_q;
  assign output_a_stable  = a_stb_q;
  assign output_b_stable  = b_stb_q;
  assign output_op_stable = op_stb_q;
  assign busy             = state_q != IDLE || count_q != '0;
  assign count            = count_q;
  assign issued           = issued_q;
endmodule

// File: tb/tb_operand_issuer.sv
// tb_operand_issuer: table vectors, directed corner sequences and a random
// run checked against a queue-based model of the command stream.
`timescale 1ns/1ps
module tb_operand_issuer;
  localparam int DEPTH = 4;
  typedef logic [66:0] cmd_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        rdy;
    int          cnt;
  } vec_t;
  logic        clk = 0, rst_n = 0, cmd_valid = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic [2:0]  cmd_op = 0;
  logic        cmd_ready, busy;
  logic [31:0] output_a, output_b;
  logic [2:0]  output_op;
  logic        output_a_stable, output_b_stable, output_op_stable;
  logic        input_a_ack, input_b_ack, input_op_ack;
  logic [2:0]  count;
  logic [7:0]  issued;
  logic        ma = 0, mb = 0, mo = 0, ca = 0, cb = 0, co = 0;
  logic        ctl_en = 0, rnd_dly = 0, mdl_en = 0;
  logic [2:0]  stbs;
  logic [31:0] ha, hb;
  logic [2:0]  hop;
  int          dly = 0, n_chk = 0, n_pass = 0, n_acc = 0, m_issued = 0;
  cmd_t        mq[$], got[$];
  vec_t        tbl[5];

  operand_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .output_a(output_a), .output_b(output_b), .output_op(output_op),
    .output_a_stable(output_a_stable), .output_b_stable(output_b_stable),
    .output_op_stable(output_op_stable),
    .input_a_ack(input_a_ack), .input_b_ack(input_b_ack), .input_op_ack(input_op_ack),
    .busy(busy), .count(count), .issued(issued)
  );

  always #5 clk = ~clk;
  assign stbs        = {output_op_stable, output_b_stable, output_a_stable};
  assign input_a_ack  = ctl_en ? ca : ma;
  assign input_b_ack  = ctl_en ? cb : mb;
  assign input_op_ack = ctl_en ? co : mo;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_stb(input int k);
    int n = 0;
    while (!stbs[k] && n < 20) begin
      step();
      n++;
    end
    chk("wait_stb", stbs[k], 1);
  endtask

  task automatic push_cmd(input vec_t v);
    cmd_valid = 1;
    cmd_a = v.a;
    cmd_b = v.b;
    cmd_op = v.op;
    step();
    cmd_valid = 0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    ctl_en = 1;
    while (got.size() < n && k < 200) begin
      step();
      k++;
    end
    chk("drain_cnt", got.size(), n);
    repeat (3) step();
    ctl_en = 0;
  endtask

  // Controller: acks each strobe after an optional random delay, one-cycle pulses.
  always @(negedge clk) begin
    ca = 0;
    cb = 0;
    co = 0;
    if (!ctl_en || !rst_n) dly = 0;
    else begin
      chk("onehot", $countones(stbs) <= 1, 1);
      if (stbs != 0) begin
        if (dly != 0) dly--;
        else begin
          dly = rnd_dly ? int'($urandom_range(0, 2)) : 0;
          if (output_a_stable) begin
            ca = 1;
            ha = output_a;
            hb = output_b;
            hop = output_op;
          end
          if (output_b_stable) begin
            cb = 1;
            chk("hold_b", {output_a, output_b, output_op}, {ha, hb, hop});
          end
          if (output_op_stable) begin
            co = 1;
            chk("hold_op", {output_a, output_b, output_op}, {ha, hb, hop});
            got.push_back({output_a, output_b, output_op});
            if (mdl_en && mq.size() != 0) chk("payload", {output_a, output_b, output_op}, mq[0]);
          end
        end
      end
    end
  end

  // Reference model: pending commands as a queue, popped when the op transfer completes.
  always @(posedge clk) begin
    if (mdl_en) begin
      bit acc;
      acc = cmd_valid && mq.size() < DEPTH;
      if (co && mq.size() != 0) begin
        void'(mq.pop_front());
        m_issued++;
      end
      if (acc) begin
        mq.push_back({cmd_a, cmd_b, cmd_op});
        n_acc++;
      end
    end
  end

  initial begin
    tbl[0] = '{32'h11111111, 32'h22222222, 3'd1, 1'b1, 1};
    tbl[1] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 3'd2, 1'b1, 2};
    tbl[2] = '{32'hDEADBEEF, 32'hCAFEF00D, 3'd5, 1'b1, 3};
    tbl[3] = '{32'h00000001, 32'hFFFFFFFF, 3'd7, 1'b1, 4};
    tbl[4] = '{32'h77777777, 32'h88888888, 3'd6, 1'b0, 4};
    step();
    step();
    chk("rst_ready", {cmd_ready, busy, count, issued}, {1'b1, 1'b0, 3'd0, 8'd0});
    chk("rst_out", {output_a, output_b, output_op, stbs}, 0);
    rst_n = 1;
    step();

    // Single command with a deliberately late A ack.
    push_cmd('{32'h3F800000, 32'h40000000, 3'b000, 1'b1, 1});
    chk("s_count", count, 1);
    chk("s_busy", busy, 1);
    chk("s_nostb", stbs, 3'b000);
    step();
    chk("s_a_stb", stbs, 3'b001);
    chk("s_data", {output_a, output_b, output_op}, {32'h3F800000, 32'h40000000, 3'b000});
    step();
    chk("s_a_hold", stbs, 3'b001);
    ma = 1;
    step();
    ma = 0;
    chk("s_b_stb", stbs, 3'b010);
    mb = 1;
    step();
    mb = 0;
    chk("s_op_stb", stbs, 3'b100);
    chk("s_data2", {output_a, output_b, output_op}, {32'h3F800000, 32'h40000000, 3'b000});
    mo = 1;
    step();
    mo = 0;
    chk("s_rel", {stbs, count, issued, busy}, {3'b000, 3'd0, 8'd1, 1'b1});
    step();
    chk("s_idle", busy, 0);
    chk("s_data3", {output_a, output_b, output_op}, {32'h3F800000, 32'h40000000, 3'b000});

    // Fill to full from the vector table with the controller stalled.
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill_rdy%0d", i), cmd_ready, tbl[i].rdy);
      push_cmd(tbl[i]);
      chk($sformatf("fill_cnt%0d", i), count, tbl[i].cnt);
    end
    chk("fill_head", {stbs, output_a}, {3'b001, tbl[0].a});
    got.delete();
    drain(4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("fill_ord%0d", i), got[i], {tbl[i].a, tbl[i].b, tbl[i].op});
    chk("fill_iss", {issued, count, busy}, {8'd5, 3'd0, 1'b0});

    // Push into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 4; i++) push_cmd(tbl[i]);
    wait_stb(0);
    ma = 1;
    step();
    ma = 0;
    wait_stb(1);
    mb = 1;
    step();
    mb = 0;
    wait_stb(2);
    mo = 1;
    cmd_valid = 1;
    cmd_a = 32'hBAD0BAD0;
    cmd_b = 32'hBAD1BAD1;
    cmd_op = 3'd4;
    chk("pf_ready", cmd_ready, 0);
    step();
    cmd_valid = 0;
    mo = 0;
    chk("pf_count", count, 3);
    got.delete();
    drain(3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk($sformatf("pf_ord%0d", i), got[i], {tbl[i+1].a, tbl[i+1].b, tbl[i+1].op});

    // Sticky acks hold the block in release wait.
    push_cmd(tbl[0]);
    push_cmd(tbl[1]);
    wait_stb(0);
    ma = 1;
    step();
    ma = 0;
    wait_stb(1);
    mb = 1;
    step();
    mb = 0;
    wait_stb(2);
    mo = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("st_stb", stbs, 3'b000);
      step();
    end
    chk("st_count", count, 1);
    mo = 0;
    ma = 1;
    step();
    chk("st_stb2", stbs, 3'b000);
    ma = 0;
    step();
    chk("st_idle", stbs, 3'b000);
    step();
    chk("st_next", {stbs, output_a}, {3'b001, tbl[1].a});
    got.delete();
    drain(1);

    // Out-of-order acks during SEND_A are ignored.
    push_cmd(tbl[2]);
    wait_stb(0);
    mo = 1;
    mb = 1;
    step();
    mo = 0;
    mb = 0;
    chk("ooo", {stbs, count, issued}, {3'b001, 3'd1, 8'd11});
    got.delete();
    drain(1);
    if (got.size() != 0) chk("ooo_data", got[0], {tbl[2].a, tbl[2].b, tbl[2].op});

    // Asynchronous reset during SEND_B with three queued commands.
    for (int i = 0; i < 3; i++) push_cmd(tbl[i]);
    wait_stb(0);
    ma = 1;
    step();
    ma = 0;
    chk("mr_pre", {stbs, count}, {3'b010, 3'd3});
    #2 rst_n = 0;
    #1;
    chk("mr_out", {output_a, output_b, output_op, stbs}, 0);
    chk("mr_state", {cmd_ready, busy, count, issued}, {1'b1, 1'b0, 3'd0, 8'd0});
    @(negedge clk);
    rst_n = 1;
    got.delete();
    ctl_en = 1;
    repeat (10) step();
    ctl_en = 0;
    chk("mr_stale", {got.size(), count, issued}, {32'd0, 3'd0, 8'd0});

    // Random run of 260 commands against the model; issued wraps to 4.
    mdl_en = 1;
    rnd_dly = 1;
    ctl_en = 1;
    for (int cyc = 0; cyc < 20000 && m_issued < 260; cyc++) begin
      chk("r_count", count, mq.size());
      chk("r_ready", cmd_ready, mq.size() < DEPTH);
      cmd_valid = n_acc < 260 && $urandom_range(0, 1) == 1;
      cmd_a = $urandom;
      cmd_b = $urandom;
      cmd_op = 3'($urandom);
      step();
    end
    cmd_valid = 0;
    chk("r_done", m_issued, 260);
    repeat (4) step();
    chk("r_final", {issued, count, busy}, {8'd4, 3'd0, 1'b0});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
